// File: rtl/bufferram_pingpong.sv
// Double-buffered frame buffer: the slave port owns the back bank, scan-out streams the front bank.
// Banks swap only on a frame boundary. Optional swap IRQ is built when BUFFERRAM_SWAP_IRQ_EN is defined.
// Ports: clk_clk/rst_reset (async, active-high); bram_* Avalon-MM-style slave on the back bank;
//        scan_* valid/ready stream of the front bank with sof/eof tags;
//        swap_req/swap_busy/swap_done/front_sel bank-swap handshake;
//        swap_irq/swap_irq_ack (only with BUFFERRAM_SWAP_IRQ_EN).
module bufferram_pingpong #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 76800,
    parameter int ADDR_W = 17,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk_clk,
    input  logic              rst_reset,
    input  logic [ADDR_W-1:0] bram_address,
    input  logic              bram_chipselect,
    input  logic              bram_clken,
    input  logic              bram_write,
    input  logic [DATA_W-1:0] bram_writedata,
    input  logic [BE_W-1:0]   bram_byteenable,
    output logic [DATA_W-1:0] bram_readdata,
    input  logic              scan_en,
    input  logic              scan_ready,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_sof,
    output logic              scan_eof,
    input  logic              swap_req,
    output logic              swap_busy,
    output logic              swap_done,
    output logic              front_sel
`ifdef BUFFERRAM_SWAP_IRQ_EN
    ,
    output logic              swap_irq,
    input  logic              swap_irq_ack
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_RUN,
        SCAN_DRAIN
    } scan_state_t;

    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    logic              slv_acc;
    logic              slv_in_range;
    logic [IDX_W-1:0]  slv_idx;

    scan_state_t       scan_state;
    scan_state_t       scan_state_d;
    logic [IDX_W-1:0]  fetch_idx;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_sof;
    logic              s1_eof;
    logic              s1_brk;
    logic              out_brk;
    logic              brk_acc;
    logic              hold;

    logic              out_free;
    logic              s1_move;
    logic              fetch;
    logic              fetch_last;
    logic              swap_exec;

    assign slv_acc      = bram_chipselect & bram_clken;
    assign slv_in_range = {1'b0, bram_address} < DEPTH_LIM;
    assign slv_idx      = bram_address[IDX_W-1:0];

    // Back bank is the one not being scanned.
    always_ff @(posedge clk_clk) begin
        if (slv_acc && bram_write && slv_in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bram_byteenable[i]) begin
                    if (front_sel)
                        bank0[slv_idx][i*8 +: 8] <= bram_writedata[i*8 +: 8];
                    else
                        bank1[slv_idx][i*8 +: 8] <= bram_writedata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            bram_readdata <= '0;
        end else if (slv_acc && !bram_write) begin
            if (!slv_in_range)
                bram_readdata <= '0;
            else if (front_sel)
                bram_readdata <= bank0[slv_idx];
            else
                bram_readdata <= bank1[slv_idx];
        end
    end

    // Two-stage scan pipe: s1 is the RAM read register, scan_* the output.
    // An eof fetched while a swap is pending is tagged (brk) and fetching
    // holds until the swap lands, so the next frame comes from the new bank.
    always_comb begin
        out_free     = !scan_valid || scan_ready;
        s1_move      = s1_valid && out_free;
        fetch        = (scan_state == SCAN_RUN) && scan_en && !hold
                       && (!s1_valid || s1_move);
        fetch_last   = fetch_idx == LAST_IDX;
        swap_exec    = swap_busy && (brk_acc || scan_state == SCAN_IDLE);
        scan_state_d = scan_state;
        unique case (scan_state)
            SCAN_IDLE:  if (scan_en) scan_state_d = SCAN_RUN;
            SCAN_RUN:   if (!scan_en) scan_state_d = SCAN_DRAIN;
            SCAN_DRAIN: if (!s1_valid && !scan_valid) scan_state_d = SCAN_IDLE;
            default:    scan_state_d = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset)
            scan_state <= SCAN_IDLE;
        else
            scan_state <= scan_state_d;
    end

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            fetch_idx  <= '0;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_sof     <= 1'b0;
            s1_eof     <= 1'b0;
            s1_brk     <= 1'b0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
            scan_sof   <= 1'b0;
            scan_eof   <= 1'b0;
            out_brk    <= 1'b0;
            brk_acc    <= 1'b0;
        end else begin
            if (fetch) begin
                s1_valid  <= 1'b1;
                s1_data   <= front_sel ? bank1[fetch_idx] : bank0[fetch_idx];
                s1_sof    <= fetch_idx == '0;
                s1_eof    <= fetch_last;
                s1_brk    <= fetch_last && swap_busy;
                fetch_idx <= fetch_last ? '0 : fetch_idx + 1'b1;
            end else begin
                if (s1_move)
                    s1_valid <= 1'b0;
                if (scan_state_d == SCAN_IDLE)
                    fetch_idx <= '0;
            end
            if (s1_move) begin
                scan_valid <= 1'b1;
                scan_data  <= s1_data;
                scan_sof   <= s1_sof;
                scan_eof   <= s1_eof;
                out_brk    <= s1_brk;
            end else if (scan_ready) begin
                scan_valid <= 1'b0;
            end
            brk_acc <= scan_valid && scan_ready && out_brk;
        end
    end

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            front_sel <= 1'b0;
            swap_busy <= 1'b0;
            swap_done <= 1'b0;
            hold      <= 1'b0;
        end else begin
            swap_done <= swap_exec;
            if (swap_exec) begin
                front_sel <= ~front_sel;
                swap_busy <= 1'b0;
                hold      <= 1'b0;
            end else begin
                if (swap_req && !swap_busy)
                    swap_busy <= 1'b1;
                if (fetch && fetch_last && swap_busy)
                    hold <= 1'b1;
            end
        end
    end

`ifdef BUFFERRAM_SWAP_IRQ_EN
    // A new swap wins over a simultaneous ack.
    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset)
            swap_irq <= 1'b0;
        else if (swap_exec)
            swap_irq <= 1'b1;
        else if (swap_irq_ack)
            swap_irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_bufferram_pingpong.sv
// Bench for bufferram_pingpong: directed slave and scan vectors, plus a
// behavioural frame-buffer model checked every cycle on the falling edge.
module tb_bufferram_pingpong;

    localparam int DW = 16;
    localparam int DEPTH = 16;
    localparam int AW = 5;

    logic          clk_clk = 1'b0;
    logic          rst_reset = 1'b1;
    logic [AW-1:0] bram_address = '0;
    logic          bram_chipselect = 1'b0;
    logic          bram_clken = 1'b1;
    logic          bram_write = 1'b0;
    logic [DW-1:0] bram_writedata = '0;
    logic [1:0]    bram_byteenable = 2'b11;
    logic [DW-1:0] bram_readdata;
    logic          scan_en = 1'b0;
    logic          scan_ready = 1'b0;
    logic          scan_valid;
    logic [DW-1:0] scan_data;
    logic          scan_sof;
    logic          scan_eof;
    logic          swap_req = 1'b0;
    logic          swap_busy;
    logic          swap_done;
    logic          front_sel;
`ifdef BUFFERRAM_SWAP_IRQ_EN
    logic          swap_irq;
    logic          swap_irq_ack = 1'b0;
`endif

    bufferram_pingpong #(
        .DATA_W(DW),
        .DEPTH(DEPTH),
        .ADDR_W(AW)
    ) dut (
        .clk_clk(clk_clk),
        .rst_reset(rst_reset),
        .bram_address(bram_address),
        .bram_chipselect(bram_chipselect),
        .bram_clken(bram_clken),
        .bram_write(bram_write),
        .bram_writedata(bram_writedata),
        .bram_byteenable(bram_byteenable),
        .bram_readdata(bram_readdata),
        .scan_en(scan_en),
        .scan_ready(scan_ready),
        .scan_valid(scan_valid),
        .scan_data(scan_data),
        .scan_sof(scan_sof),
        .scan_eof(scan_eof),
        .swap_req(swap_req),
        .swap_busy(swap_busy),
        .swap_done(swap_done),
        .front_sel(front_sel)
`ifdef BUFFERRAM_SWAP_IRQ_EN
        ,
        .swap_irq(swap_irq),
        .swap_irq_ack(swap_irq_ack)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model state: written only by the compare process.
    logic [DW-1:0] mm [2][DEPTH];
    logic          m_front = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [DW-1:0] m_rd = '0;
    int            m_idx = 0;
    int            m_bank = 0;
    int            sw_cnt = 0;
    int            seen_gen = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] pv_data = '0;
    logic          pv_sof = 1'b0;
    logic          pv_eof = 1'b0;

    // Written only by the stimulus process.
    int            start_gen = 0;
    logic          m_idle = 1'b1;

    always @(negedge clk_clk) begin
        if (rst_reset) begin
            m_front    = 1'b0;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_rd       = '0;
            m_idx      = 0;
            m_bank     = 0;
            sw_cnt     = 0;
            prev_stall = 1'b0;
            seen_gen   = start_gen;
        end else begin
            chk("front_sel", front_sel, m_front);
            chk("swap_busy", swap_busy, m_busy);
            chk("swap_done", swap_done, m_done);
            chk("readdata", bram_readdata, m_rd);
            if (seen_gen != start_gen) begin
                seen_gen = start_gen;
                m_idx    = 0;
                m_bank   = m_front ? 1 : 0;
            end
            if (prev_stall) begin
                chk("stall_valid", scan_valid, 1);
                chk("stall_data", scan_data, pv_data);
                chk("stall_sof", scan_sof, pv_sof);
                chk("stall_eof", scan_eof, pv_eof);
            end
            if (scan_valid) begin
                chk("scan_data", scan_data, mm[m_bank][m_idx]);
                chk("scan_sof", scan_sof, m_idx == 0);
                chk("scan_eof", scan_eof, m_idx == DEPTH - 1);
            end
            prev_stall = scan_valid && !scan_ready;
            pv_data    = scan_data;
            pv_sof     = scan_sof;
            pv_eof     = scan_eof;
            if (scan_valid && scan_ready) begin
                if (m_idx == DEPTH - 1) begin
                    m_idx = 0;
                    if (m_busy) begin
                        sw_cnt = 2;
                        m_bank = m_front ? 0 : 1;
                    end else begin
                        m_bank = m_front ? 1 : 0;
                    end
                end else begin
                    m_idx++;
                end
            end
            if (bram_chipselect && bram_clken) begin
                if (bram_write) begin
                    if (int'(bram_address) < DEPTH)
                        for (int b = 0; b < 2; b++)
                            if (bram_byteenable[b])
                                mm[m_front ? 0 : 1][bram_address][b*8 +: 8] = bram_writedata[b*8 +: 8];
                end else begin
                    m_rd = (int'(bram_address) < DEPTH) ? mm[m_front ? 0 : 1][bram_address] : '0;
                end
            end
            m_done = 1'b0;
            if (sw_cnt == 1 || (m_busy && sw_cnt == 0 && m_idle)) begin
                m_front = !m_front;
                m_busy  = 1'b0;
                m_done  = 1'b1;
            end else if (swap_req && !m_busy) begin
                m_busy = 1'b1;
            end
            if (sw_cnt > 0)
                sw_cnt--;
        end
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic slv_wr(input int a, input logic [DW-1:0] d, input logic [1:0] be);
        bram_chipselect = 1'b1;
        bram_clken      = 1'b1;
        bram_write      = 1'b1;
        bram_address    = AW'(a);
        bram_writedata  = d;
        bram_byteenable = be;
        tick();
        bram_chipselect = 1'b0;
        bram_write      = 1'b0;
    endtask

    task automatic slv_rd(input int a);
        bram_chipselect = 1'b1;
        bram_clken      = 1'b1;
        bram_write      = 1'b0;
        bram_address    = AW'(a);
        tick();
        bram_chipselect = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] pat;
        pat = 40'hB53C96E14D;
        tick();
        tick();
        chk("rst_front_sel", front_sel, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_readdata", bram_readdata, 0);
        rst_reset = 1'b0;
        tick();

        for (int k = 0; k < DEPTH; k++)
            slv_wr(k, 16'hA000 + DW'(k), 2'b11);
        slv_rd(5);
        chk("rd_addr5", bram_readdata, 16'hA005);
        slv_rd(DEPTH);
        chk("rd_out_of_range", bram_readdata, 16'h0000);
        slv_wr(DEPTH, 16'hDEAD, 2'b11);
        slv_rd(0);
        chk("oob_write_dropped", bram_readdata, 16'hA000);
        slv_wr(3, 16'hFFFF, 2'b11);
        slv_wr(3, 16'h1234, 2'b01);
        slv_rd(3);
        chk("byteenable_merge", bram_readdata, 16'hFF34);
        bram_chipselect = 1'b1;
        bram_clken      = 1'b0;
        bram_address    = AW'(7);
        tick();
        tick();
        chk("clken_hold", bram_readdata, 16'hFF34);
        bram_chipselect = 1'b0;
        bram_clken      = 1'b1;
        slv_wr(3, 16'hA003, 2'b11);

        pulse_swap();
        tick();
        tick();
        chk("idle_swap_front", front_sel, 1);
`ifdef BUFFERRAM_SWAP_IRQ_EN
        chk("irq_set", swap_irq, 1);
        swap_irq_ack = 1'b1;
        tick();
        swap_irq_ack = 1'b0;
        chk("irq_cleared", swap_irq, 0);
`endif
        for (int k = 0; k < DEPTH; k++)
            slv_wr(k, DW'(k), 2'b11);
        pulse_swap();
        tick();
        tick();
        chk("idle_swap_back", front_sel, 0);

        m_idle     = 1'b0;
        start_gen++;
        scan_en    = 1'b1;
        scan_ready = 1'b1;
        tick();
        tick();
        chk("lat_n1_valid", scan_valid, 0);
        tick();
        chk("lat_n2_valid", scan_valid, 1);
        chk("lat_n2_data", scan_data, 16'h0000);
        chk("lat_n2_sof", scan_sof, 1);
        for (int i = 0; i < 24; i++)
            tick();

        for (int i = 0; i < 40; i++) begin
            scan_ready = pat[i];
            tick();
        end
        scan_ready = 1'b1;

        for (int i = 0; i < 40 && m_idx != 4; i++)
            tick();
        pulse_swap();
        tick();
        tick();
        chk("busy_mid_frame", swap_busy, 1);
        pulse_swap();
        for (int i = 0; i < 40 && !(front_sel && scan_valid && scan_sof); i++)
            tick();
        chk("new_front_sof_data", scan_data, 16'hA000);
        chk("new_front_sel", front_sel, 1);
        chk("second_req_ignored", swap_busy, 0);

        slv_wr(2, 16'h5555, 2'b11);
        slv_rd(2);
        chk("back_bank_rw", bram_readdata, 16'h5555);
        for (int i = 0; i < 10; i++)
            tick();

        scan_en = 1'b0;
        for (int i = 0; i < 6; i++)
            tick();
        chk("drained_valid", scan_valid, 0);
        m_idle = 1'b1;
        tick();

        m_idle = 1'b0;
        start_gen++;
        scan_en = 1'b1;
        for (int i = 0; i < 6; i++)
            tick();
        pulse_swap();
        tick();
        chk("busy_before_reset", swap_busy, 1);
        @(posedge clk_clk);
        #2;
        rst_reset = 1'b1;
        #1;
        chk("async_rst_front_sel", front_sel, 0);
        chk("async_rst_busy", swap_busy, 0);
        chk("async_rst_done", swap_done, 0);
        chk("async_rst_valid", scan_valid, 0);
        chk("async_rst_sof", scan_sof, 0);
        chk("async_rst_eof", scan_eof, 0);
        chk("async_rst_data", scan_data, 0);
        chk("async_rst_readdata", bram_readdata, 0);
`ifdef BUFFERRAM_SWAP_IRQ_EN
        chk("async_rst_irq", swap_irq, 0);
`endif
        scan_en = 1'b0;
        m_idle  = 1'b1;
        tick();
        tick();
        rst_reset = 1'b0;
        tick();
        tick();
        chk("post_rst_front_sel", front_sel, 0);
        chk("post_rst_valid", scan_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
